// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pkg
// Description : Shared types and constants for the conv2d operand feeders:
//               activation width, saturation limits, packer FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

endpackage
`default_nettype wire

// File: rtl/act_outlier_classify.sv
`default_nettype none
// ============================================================================
// Module      : act_outlier_classify
// Description : Combinational outlier test for one activation. The magnitude
//               is formed one bit wider than the data so |INT_MIN| does not
//               wrap. Also supplies the sign-matched saturation value.
// Revision    : 1.0 - initial release
// ============================================================================
module act_outlier_classify
  import conv_pkg::*;
(
  input  act_t              i_a,
  input  logic [DATA_W-1:0] i_threshold,
  output logic              o_is_outlier,
  output act_t              o_sat_value
);

  logic [DATA_W:0] w_ext;
  logic [DATA_W:0] w_mag;

  assign w_ext = {i_a[DATA_W-1], i_a};
  assign w_mag = i_a[DATA_W-1] ? (~w_ext + (DATA_W+1)'(1)) : w_ext;

  // Strictly greater: a magnitude equal to the threshold stays an inlier.
  assign o_is_outlier = (w_mag > {1'b0, i_threshold});

  // Outliers are never zero, so the sign bit alone picks the saturation rail.
  assign o_sat_value = i_a[DATA_W-1] ? INT_MIN : INT_MAX;

endmodule
`default_nettype wire

// File: rtl/act_outlier_packer.sv
`default_nettype none
// ============================================================================
// Module      : act_outlier_packer
// Description : Packs a stream of signed activations into G-lane groups,
//               flagging outliers routed to the FP path (up to cfg_m per
//               group) and saturating the outliers past that budget.
// Revision    : 1.0 - initial release
// ============================================================================
module act_outlier_packer
  import conv_pkg::*;
#(
  parameter int G     = 8,
  parameter int CNT_W = $clog2(G+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   cfg_threshold,
  input  logic [CNT_W-1:0]    cfg_m,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [G*DATA_W-1:0] out_data,
  output logic [G-1:0]        out_ovf,
  output logic [G-1:0]        out_sat,
  output logic [CNT_W-1:0]    out_outlier_cnt,
  output logic                out_last,
  output logic [31:0]         stat_sat_total
);

  localparam int IDX_W = (G > 1) ? $clog2(G) : 1;

  pack_state_e              r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [CNT_W-1:0]         r_oc;
  logic [CNT_W-1:0]         r_m;
  logic [DATA_W-1:0]        r_thr;
  logic [G-1:0][DATA_W-1:0] r_lane;
  logic [G-1:0]             r_ovf;
  logic [G-1:0]             r_sat;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_last;
  logic [31:0]              r_stat;

  logic                     w_accept;
  logic                     w_first;
  logic [DATA_W-1:0]        w_thr;
  logic [CNT_W-1:0]         w_m;
  logic                     w_is_outlier;
  act_t                     w_sat_value;
  logic                     w_in_budget;
  logic [DATA_W-1:0]        w_lane_val;
  logic                     w_close;
  logic [31:0]              w_pop;
  logic [32:0]              w_stat_sum;

  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (r_idx == '0);

  // Lane 0 classifies against the live config, which is latched in the same
  // edge; later lanes use the latched copy so mid-group changes are deferred.
  assign w_thr = w_first ? cfg_threshold : r_thr;
  assign w_m   = w_first ? cfg_m : r_m;

  act_outlier_classify u_classify (
    .i_a          (in_data),
    .i_threshold  (w_thr),
    .o_is_outlier (w_is_outlier),
    .o_sat_value  (w_sat_value)
  );

  assign w_in_budget = (r_oc < w_m);
  assign w_lane_val  = (w_is_outlier && !w_in_budget) ? w_sat_value : in_data;
  assign w_close     = (r_idx == IDX_W'(G-1)) | in_last;

  // Number of saturated lanes in the group currently held on the output.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < G; i++) begin
      w_pop = w_pop + 32'(r_sat[i]);
    end
  end

  assign w_stat_sum = {1'b0, r_stat} + {1'b0, w_pop};

  // Packer FSM: fill lanes in arrival order, then hold the group until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_oc        <= '0;
      r_m         <= '0;
      r_thr       <= '0;
      r_lane      <= '0;
      r_ovf       <= '0;
      r_sat       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_stat      <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_first) begin
              r_thr <= cfg_threshold;
              r_m   <= cfg_m;
            end
            r_lane[r_idx] <= w_lane_val;
            r_ovf[r_idx]  <= w_is_outlier & w_in_budget;
            r_sat[r_idx]  <= w_is_outlier & ~w_in_budget;
            if (w_is_outlier && w_in_budget) begin
              r_oc <= r_oc + CNT_W'(1);
            end
            if (w_close) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_last      <= in_last;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_oc        <= '0;
            r_lane      <= '0;
            r_ovf       <= '0;
            r_sat       <= '0;
            r_last      <= 1'b0;
            r_stat      <= w_stat_sum[32] ? 32'hFFFF_FFFF : w_stat_sum[31:0];
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign out_data        = r_lane;
  assign out_ovf         = r_ovf;
  assign out_sat         = r_sat;
  assign out_outlier_cnt = r_oc;
  assign out_last        = r_last;
  assign stat_sat_total  = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_act_outlier_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_outlier_packer
// Description : Directed, table-driven bench for act_outlier_packer (G=8),
//               plus hand-written stall, config-latch and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_outlier_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [31:0]  cfg_threshold;
  logic [3:0]   cfg_m;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [7:0]   out_ovf;
  logic [7:0]   out_sat;
  logic [3:0]   out_outlier_cnt;
  logic         out_last;
  logic [31:0]  stat_sat_total;

  int total = 0;
  int bad   = 0;

  act_outlier_packer #(.G(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .cfg_threshold   (cfg_threshold),
    .cfg_m           (cfg_m),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_ovf         (out_ovf),
    .out_sat         (out_sat),
    .out_outlier_cnt (out_outlier_cnt),
    .out_last        (out_last),
    .stat_sat_total  (stat_sat_total)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       n;
    logic             last;
    logic [31:0]      thr;
    logic [3:0]       m;
    logic [7:0][31:0] din;
    logic [7:0][31:0] dexp;
    logic [7:0]       ovf;
    logic [7:0]       sat;
    logic [3:0]       cnt;
    logic [31:0]      stat;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0][31:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic vec_t mk(input int n, input logic last, input logic [31:0] thr, input logic [3:0] m,
                              input logic [7:0][31:0] din, input logic [7:0][31:0] dexp,
                              input logic [7:0] ovf, input logic [7:0] sat, input logic [3:0] cnt,
                              input logic [31:0] stat);
    vec_t v;
    v.n = 4'(n); v.last = last; v.thr = thr; v.m = m; v.din = din; v.dexp = dexp;
    v.ovf = ovf; v.sat = sat; v.cnt = cnt; v.stat = stat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one activation and wait (bounded) until it is accepted.
  task automatic push(input logic [31:0] d, input logic l);
    int w = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the closing accept: check the held group, then take it.
  task automatic chk_group(input string tag, input logic [7:0][31:0] d, input logic [7:0] ovf,
                           input logic [7:0] sat, input logic [3:0] cnt, input logic last,
                           input logic [31:0] stat);
    chk({tag, "_valid"}, 256'(out_valid), 256'(1'b1));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_ovf"}, 256'(out_ovf), 256'(ovf));
    chk({tag, "_sat"}, 256'(out_sat), 256'(sat));
    chk({tag, "_cnt"}, 256'(out_outlier_cnt), 256'(cnt));
    chk({tag, "_last"}, 256'(out_last), 256'(last));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_stat"}, 256'(stat_sat_total), 256'(stat));
    chk({tag, "_drop"}, 256'(out_valid), 256'(1'b0));
  endtask

  initial begin
    vecs[0] = mk(8, 1'b0, 100, 2, pk8(1, 2, 3, 4, 5, 6, 7, 8), pk8(1, 2, 3, 4, 5, 6, 7, 8),
                 8'h00, 8'h00, 0, 0);
    vecs[1] = mk(8, 1'b0, 100, 2, pk8(200, -300, 400, -500, 5, 6, 7, 8),
                 pk8(200, -300, 32'h7FFF_FFFF, 32'h8000_0000, 5, 6, 7, 8), 8'h03, 8'h0C, 2, 2);
    vecs[2] = mk(3, 1'b1, 100, 2, pk8(10, 20, 30, 0, 0, 0, 0, 0), pk8(10, 20, 30, 0, 0, 0, 0, 0),
                 8'h00, 8'h00, 0, 2);
    vecs[3] = mk(1, 1'b1, 32'h7FFF_FFFF, 0, pk8(32'h8000_0000, 0, 0, 0, 0, 0, 0, 0),
                 pk8(32'h8000_0000, 0, 0, 0, 0, 0, 0, 0), 8'h00, 8'h01, 0, 3);
    vecs[4] = mk(8, 1'b1, 100, 0, pk8(100, -100, 101, -101, 0, 99, -99, 100),
                 pk8(100, -100, 32'h7FFF_FFFF, 32'h8000_0000, 0, 99, -99, 100), 8'h00, 8'h0C, 0, 5);
    vecs[5] = mk(8, 1'b0, 0, 8, pk8(1, -1, 0, 2, -2, 3, 0, 5), pk8(1, -1, 0, 2, -2, 3, 0, 5),
                 8'hBB, 8'h00, 6, 5);
    vecs[6] = mk(4, 1'b1, 10, 1, pk8(5, -20, 30, -40, 0, 0, 0, 0),
                 pk8(5, -20, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 0), 8'h02, 8'h0C, 1, 7);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_threshold = '0; cfg_m = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_stat", 256'(stat_sat_total), 256'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

    for (int v = 0; v < 7; v++) begin
      cfg_threshold = vecs[v].thr;
      cfg_m         = vecs[v].m;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        push(vecs[v].din[k], vecs[v].last && (k == int'(vecs[v].n) - 1));
      end
      chk_group($sformatf("vec%0d", v), vecs[v].dexp, vecs[v].ovf, vecs[v].sat,
                vecs[v].cnt, vecs[v].last, vecs[v].stat);
    end

    // Stall in HOLD with a producer trying to push; the group must not move.
    cfg_threshold = 100; cfg_m = 2;
    for (int k = 0; k < 8; k++) push(32'(k + 1), 1'b0);
    in_valid = 1'b1; in_data = 999;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 256'(out_valid), 256'(1'b1));
      chk("hold_in_ready", 256'(in_ready), 256'(1'b0));
      chk("hold_data", out_data, pk8(1, 2, 3, 4, 5, 6, 7, 8));
    end
    in_valid = 1'b0;
    chk_group("hold", pk8(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 8'h00, 0, 1'b0, 7);
    push(42, 1'b1);
    chk_group("after_hold", pk8(42, 0, 0, 0, 0, 0, 0, 0), 8'h00, 8'h00, 0, 1'b1, 7);

    // Config changes after lane 0 must not affect the rest of the group.
    cfg_threshold = 100; cfg_m = 1;
    push(200, 1'b0);
    cfg_threshold = 0; cfg_m = 8;
    for (int k = 0; k < 7; k++) push(32'(300 - 295 * (k > 0 ? 1 : 0) + (k > 0 ? k - 1 : 0)), 1'b0);
    chk_group("cfg_latch", pk8(200, 32'h7FFF_FFFF, 5, 6, 7, 8, 9, 10), 8'h01, 8'h02, 1, 1'b0, 8);

    // Reset in the middle of a group discards the partial lanes and counters.
    cfg_threshold = 100; cfg_m = 2;
    for (int k = 0; k < 4; k++) push(32'(500 + 100 * k), 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 256'(out_valid), 256'(1'b0));
    chk("midrst_stat", 256'(stat_sat_total), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    push(200, 1'b0); push(300, 1'b0); push(400, 1'b0);
    for (int k = 1; k <= 5; k++) push(32'(k), 1'b0);
    chk_group("fresh", pk8(200, 300, 32'h7FFF_FFFF, 1, 2, 3, 4, 5), 8'h03, 8'h04, 2, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
